hazard_unit: RTL and testbench

Pipeline hazard controller for the five-stage RISC-V core. It consumes the register-address, write-enable and branch-decision taps that the datapath exports, and drives back the stall, flush and forwarding selects. It also runs a memory-wait state machine that freezes the pipeline while the data memory is busy, with a timeout watchdog. Optional performance counters can be compiled in.

---
 rtl/hazard_unit.sv | 168 ++++++++++++++++
 tb/tb_hazard_unit.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_unit.sv
// Hazard controller for the five-stage RISC-V pipeline: forwarding, load-use stall, branch flush,
// memory-wait FSM with timeout watchdog. Define HAZ_PERF_CNT_EN to add stall/flush counters.
module hazard_unit #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 32
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic [4:0]       RdM,
    input  logic [4:0]       RdW,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             ResultSrcE0,
    input  logic             PCSrcE,
    input  logic             MemReqM,
    input  logic             MemReadyM,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             MemErr,
    output logic             dbg_state
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] StallCnt,
    output logic [CNT_W-1:0] FlushCnt
`endif
);

    localparam int WD_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    generate
        if (TIMEOUT < 1 || CNT_W < 1) begin : g_param_check
            $error("hazard_unit: TIMEOUT and CNT_W must be positive");
        end
    endgenerate

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic            mem_err_q, mem_err_d;
    logic            mem_stall;
    logic            lw_hazard;

    always_comb begin
        ForwardAE = 2'b00;
        if (RegWriteM && RdM != 5'd0 && RdM == Rs1E)
            ForwardAE = 2'b10;
        else if (RegWriteW && RdW != 5'd0 && RdW == Rs1E)
            ForwardAE = 2'b01;

        ForwardBE = 2'b00;
        if (RegWriteM && RdM != 5'd0 && RdM == Rs2E)
            ForwardBE = 2'b10;
        else if (RegWriteW && RdW != 5'd0 && RdW == Rs2E)
            ForwardBE = 2'b01;
    end

    // Reset gates the freeze so stalls drop the instant RST_N falls, not at the next edge.
    assign mem_stall = RST_N && MemReqM && !MemReadyM;
    assign lw_hazard = ResultSrcE0 && RdE != 5'd0 && (RdE == Rs1D || RdE == Rs2D);

    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushW = 1'b0;
        if (mem_stall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
        end else if (RST_N) begin
            // A taken branch squashes the load-use bubble: flush only, never stall.
            StallF = lw_hazard && !PCSrcE;
            StallD = lw_hazard && !PCSrcE;
            FlushD = PCSrcE;
            FlushE = PCSrcE || lw_hazard;
        end
    end

    always_comb begin
        state_d   = state_q;
        wd_d      = wd_q;
        mem_err_d = mem_err_q;
        case (state_q)
            ST_RUN: begin
                wd_d = '0;
                if (MemReqM && !MemReadyM)
                    state_d = ST_MEM_WAIT;
            end
            ST_MEM_WAIT: begin
                if (MemReadyM) begin
                    state_d = ST_RUN;
                    wd_d    = '0;
                end else if (wd_q + WD_W'(1) >= WD_W'(TIMEOUT)) begin
                    mem_err_d = 1'b1;
                    state_d   = ST_RUN;
                    wd_d      = '0;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= ST_RUN;
            wd_q      <= '0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wd_q      <= wd_d;
            mem_err_q <= mem_err_d;
        end
    end

    assign MemErr    = mem_err_q;
    assign dbg_state = (state_q == ST_MEM_WAIT);

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (StallF && stall_cnt_q != '1)
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (FlushD && flush_cnt_q != '1)
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign StallCnt = stall_cnt_q;
    assign FlushCnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed scenarios plus randomized traffic against a
// behavioural model of the forwarding, stall/flush and memory-wait rules.
module tb_hazard_unit;

    localparam int TMO = 4;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic        RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, MemReqM, MemReadyM;
    logic        StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
    logic [1:0]  ForwardAE, ForwardBE;
    logic        MemErr, dbg_state;
`ifdef HAZ_PERF_CNT_EN
    logic [31:0] StallCnt, FlushCnt;
`endif

    hazard_unit #(.TIMEOUT(TMO), .CNT_W(32)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .ResultSrcE0(ResultSrcE0),
        .PCSrcE(PCSrcE), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .MemErr(MemErr), .dbg_state(dbg_state)
`ifdef HAZ_PERF_CNT_EN
        , .StallCnt(StallCnt), .FlushCnt(FlushCnt)
`endif
    );

    // clock / time limit
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL time_limit simulation did not finish");
        $fatal(1);
    end

    int n_checks = 0;
    int n_errors = 0;
    logic [10:0] exp_q[$];

    // behavioural model state
    bit m_wait;
    int m_wait_cycles;
    bit m_err;
    int m_stall_cnt;
    int m_flush_cnt;

    int stall_f_seen, stall_m_seen, flush_d_seen;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] model_fwd(input logic [4:0] rs);
        if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
        if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    // {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW,ForwardAE,ForwardBE}
    function automatic logic [10:0] model_out();
        bit frozen, load_use;
        logic [6:0] ctl;
        frozen   = MemReqM && !MemReadyM;
        load_use = ResultSrcE0 && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
        if (!RST_N)
            ctl = 7'b0000000;
        else if (frozen)
            ctl = 7'b1111001;
        else if (PCSrcE)
            ctl = 7'b0000110;
        else if (load_use)
            ctl = 7'b1100010;
        else
            ctl = 7'b0000000;
        return {ctl, model_fwd(Rs1E), model_fwd(Rs2E)};
    endfunction

    task automatic model_reset();
        m_wait = 0;
        m_wait_cycles = 0;
        m_err = 0;
        m_stall_cnt = 0;
        m_flush_cnt = 0;
    endtask

    task automatic model_step(input logic [10:0] outs);
        if (!RST_N) begin
            model_reset();
            return;
        end
        if (outs[10]) m_stall_cnt++;
        if (outs[6])  m_flush_cnt++;
        if (!m_wait) begin
            if (MemReqM && !MemReadyM) m_wait = 1;
            m_wait_cycles = 0;
        end else if (MemReadyM) begin
            m_wait = 0;
            m_wait_cycles = 0;
        end else begin
            m_wait_cycles++;
            if (m_wait_cycles == TMO) begin
                m_err = 1;
                m_wait = 0;
                m_wait_cycles = 0;
            end
        end
    endtask

    // driver: inputs are set at the negedge; sample #1 later, then advance one clock
    task automatic clear_inputs();
        {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
        {RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, MemReqM, MemReadyM} = '0;
    endtask

    task automatic cycle(input string tag);
        logic [10:0] exp;
        logic [10:0] got;
        #1;
        if (!RST_N) model_reset();
        exp = model_out();
        exp_q.push_back(exp);
        got = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, ForwardAE, ForwardBE};
        check({tag, "/outs"}, {21'b0, got}, {21'b0, exp_q.pop_front()});
        check({tag, "/mem_err"}, {31'b0, MemErr}, {31'b0, m_err});
        check({tag, "/state"}, {31'b0, dbg_state}, {31'b0, m_wait});
`ifdef HAZ_PERF_CNT_EN
        check({tag, "/stall_cnt"}, StallCnt, m_stall_cnt);
        check({tag, "/flush_cnt"}, FlushCnt, m_flush_cnt);
`endif
        stall_f_seen += StallF;
        stall_m_seen += StallM;
        flush_d_seen += FlushD;
        @(posedge CLK);
        model_step(exp);
        @(negedge CLK);
    endtask

    task automatic clear_seen();
        stall_f_seen = 0;
        stall_m_seen = 0;
        flush_d_seen = 0;
    endtask

    initial begin
        clear_inputs();
        model_reset();
        clear_seen();
        RST_N = 1'b0;
        repeat (2) @(negedge CLK);
        cycle("reset");
        check("reset_stall_f", {31'b0, StallF}, 0);
        check("reset_mem_err", {31'b0, MemErr}, 0);
        RST_N = 1'b1;
        cycle("idle");

        // forwarding priority M over W, then W alone
        RdM = 5; RegWriteM = 1; Rs1E = 5; RdW = 5; RegWriteW = 1;
        #1 check("fwd_m_prio", {30'b0, ForwardAE}, 2'b10);
        cycle("fwd_m");
        RdM = 0;
        #1 check("fwd_w", {30'b0, ForwardAE}, 2'b01);
        cycle("fwd_w");
        Rs2E = 5; RegWriteW = 0;
        #1 check("fwd_none", {30'b0, ForwardBE}, 2'b00);
        cycle("fwd_none");
        clear_inputs();

        // load-use: one bubble, then the load sits in M
        clear_seen();
        ResultSrcE0 = 1; RdE = 3; Rs2D = 3;
        cycle("lw_hit");
        ResultSrcE0 = 0; RdE = 0; Rs2D = 0; RdM = 3; RegWriteM = 1;
        cycle("lw_after");
        check("lw_one_bubble", stall_f_seen, 1);
        clear_inputs();
        ResultSrcE0 = 1; RdE = 0; Rs1D = 0;
        #1 check("lw_x0_no_stall", {31'b0, StallF}, 0);
        cycle("lw_x0");

        // load-use coinciding with a taken branch
        ResultSrcE0 = 1; RdE = 7; Rs1D = 7; PCSrcE = 1;
        #1 check("lw_br_stall", {31'b0, StallF}, 0);
        check("lw_br_flush", {30'b0, FlushD, FlushE}, 2'b11);
        cycle("lw_br");
        clear_inputs();

        // memory wait: request cycle + 3 wait cycles, branch held throughout
        clear_seen();
        MemReqM = 1; PCSrcE = 1;
        repeat (4) cycle("mem_wait");
        MemReadyM = 1;
        cycle("mem_release");
        MemReqM = 0; MemReadyM = 0; PCSrcE = 0;
        cycle("mem_done");
        check("mem_stall_len", stall_m_seen, 4);
        check("mem_flush_once", flush_d_seen, 1);

        // watchdog timeout
        MemReqM = 1;
        repeat (TMO + 1) cycle("tmo_wait");
        check("tmo_err", {31'b0, MemErr}, 1);
        check("tmo_run", {31'b0, dbg_state}, 0);
        MemReqM = 0;
        repeat (3) cycle("tmo_sticky");
        check("tmo_sticky", {31'b0, MemErr}, 1);

        // asynchronous reset in the middle of MEM_WAIT
        MemReqM = 1;
        repeat (2) cycle("rst_wait");
        RST_N = 0;
        #1 check("rst_async_stall", {31'b0, StallF}, 0);
        check("rst_async_state", {31'b0, dbg_state}, 0);
        check("rst_clears_err", {31'b0, MemErr}, 0);
        cycle("rst_low");
        RST_N = 1; MemReqM = 0;
        cycle("rst_release");

`ifdef HAZ_PERF_CNT_EN
        RST_N = 0;
        cycle("perf_rst");
        RST_N = 1;
        clear_inputs();
        ResultSrcE0 = 1; RdE = 2; Rs1D = 2;
        cycle("perf_lw1");
        clear_inputs();
        cycle("perf_gap");
        ResultSrcE0 = 1; RdE = 4; Rs2D = 4;
        cycle("perf_lw2");
        clear_inputs();
        PCSrcE = 1;
        cycle("perf_br");
        clear_inputs();
        cycle("perf_idle");
        check("perf_stall_cnt", StallCnt, 2);
        check("perf_flush_cnt", FlushCnt, 1);
        RST_N = 0;
        #1 check("perf_rst_stall", StallCnt, 0);
        check("perf_rst_flush", FlushCnt, 0);
        cycle("perf_rst2");
        RST_N = 1;
`endif

        // randomized traffic over a small register set to provoke matches
        for (int i = 0; i < 400; i++) begin
            Rs1D = 5'($urandom_range(0, 3));
            Rs2D = 5'($urandom_range(0, 3));
            Rs1E = 5'($urandom_range(0, 3));
            Rs2E = 5'($urandom_range(0, 3));
            RdE  = 5'($urandom_range(0, 3));
            RdM  = 5'($urandom_range(0, 3));
            RdW  = 5'($urandom_range(0, 3));
            RegWriteM   = 1'($urandom_range(0, 1));
            RegWriteW   = 1'($urandom_range(0, 1));
            ResultSrcE0 = 1'($urandom_range(0, 1));
            PCSrcE      = ($urandom_range(0, 3) == 0);
            MemReqM     = ($urandom_range(0, 2) == 0);
            MemReadyM   = ($urandom_range(0, 2) != 0);
            cycle("rand");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
